// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//   Shared definitions for the two-layer time-multiplexed LIF classifier.
//   - snn_state_e : sequencing FSM states of snn_two_layer_seq
//   - DEF_*       : default parameter values of the classifier
//   - sat_add     : signed add clamped to a mem_w-bit signed range
//
//   Optional build macro used by the neuron: SNN_SOFT_RESET_EN
//   (subtractive reset on fire instead of reset-to-zero).
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam int DEF_N_IN       = 25;
  localparam int DEF_N_HID      = 5;
  localparam int DEF_N_OUT      = 2;
  localparam int DEF_W_W        = 8;
  localparam int DEF_MEM_W      = 16;
  localparam int DEF_THRESH     = 64;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_T_STEPS    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC1  = 3'd1,
    S_FIRE1 = 3'd2,
    S_ACC2  = 3'd3,
    S_FIRE2 = 3'd4,
    S_DONE  = 3'd5
  } snn_state_e;

  // Operands arrive sign-extended to 32 bits. The sum is formed one bit wider
  // than the operands so it can never wrap; for the membrane widths this block
  // supports (up to 30 bits) that is at least MEM_W+2 bits, and the clamp to
  // [-2^(mem_w-1), 2^(mem_w-1)-1] gives the same result as a MEM_W+2 bit sum.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int mem_w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (mem_w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (mem_w - 1));
    if (sum > hi) begin
      return 32'(hi);
    end else if (sum < lo) begin
      return 32'(lo);
    end else begin
      return 32'(sum);
    end
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// ---------------------------------------------------------------------------
// snn_lif_neuron
//   One leaky integrate-and-fire neuron holding a single signed membrane.
//   The owning sequencer presents one synaptic weight per accumulate cycle and
//   the bias on the fire cycle; the neuron never sequences anything itself.
//
//   Build macro: SNN_SOFT_RESET_EN
//     defined     -> on fire, membrane keeps the residual v - THRESH
//     not defined -> on fire, membrane is cleared to 0
//
//   Ports
//     clk, reset  : clock, synchronous active-high reset (clears mem and spike)
//     acc_en_i    : add weight_i to the membrane this cycle (saturating)
//     weight_i    : signed synaptic weight, W_W bits
//     fire_en_i   : leak, add bias, threshold, update spike (saturating)
//     bias_i      : signed bias, W_W bits
//     spk_o       : spike decided on the last fire cycle, held until the next
// ---------------------------------------------------------------------------
import snn_pkg::*;

module snn_lif_neuron #(
  parameter int W_W        = DEF_W_W,
  parameter int MEM_W      = DEF_MEM_W,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           acc_en_i,
  input  logic [W_W-1:0] weight_i,
  input  logic           fire_en_i,
  input  logic [W_W-1:0] bias_i,
  output logic           spk_o
);

  logic signed [MEM_W-1:0] mem_q, mem_d;
  logic                    spk_q, spk_d;
  logic signed [W_W-1:0]   w_s;
  logic signed [W_W-1:0]   b_s;
  logic signed [31:0]      fire_sum;
  logic                    fire;

  always_comb begin
    w_s = weight_i;
    b_s = bias_i;
    // v = mem + bias - (mem >>> LEAK_SHIFT); the leak uses the membrane as it
    // stands after this timestep's accumulation.
    fire_sum = sat_add(32'(mem_q), 32'(b_s) - 32'(mem_q >>> LEAK_SHIFT), MEM_W);
    fire     = (fire_sum >= 32'(THRESH));

    mem_d = mem_q;
    spk_d = spk_q;
    if (acc_en_i) begin
      mem_d = MEM_W'(sat_add(32'(mem_q), 32'(w_s), MEM_W));
    end else if (fire_en_i) begin
      spk_d = fire;
      if (fire) begin
`ifdef SNN_SOFT_RESET_EN
        // v >= THRESH > 0, so the residual is non-negative and always fits.
        mem_d = MEM_W'(fire_sum - 32'(THRESH));
`else
        mem_d = '0;
`endif
      end else begin
        mem_d = fire_sum[MEM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      spk_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      spk_q <= spk_d;
    end
  end

  assign spk_o = spk_q;

endmodule

// File: rtl/snn_two_layer_seq.sv
// ---------------------------------------------------------------------------
// snn_two_layer_seq
//   Time-multiplexed two-layer LIF spiking classifier. Each accepted pulse runs
//   one timestep: layer 1 integrates the latched input spikes one input per
//   cycle and fires, then layer 2 integrates the hidden spikes one per cycle
//   and fires. Output spikes are counted over T_STEPS timesteps and the argmax
//   (ties to lowest index) is reported with a one-cycle valid strobe.
//
//   Build macro: SNN_SOFT_RESET_EN (subtractive reset in every neuron).
//
//   Ports
//     clk, reset    : clock, synchronous active-high reset (top priority)
//     pulse         : timestep strobe, accepted only in IDLE
//     pixel_spk     : input spikes, captured on the accepting edge
//     weights_l1    : input i -> hidden j at [(j*N_IN+i)*W_W +: W_W], signed
//     bias_l1       : hidden j at [j*W_W +: W_W], signed
//     weights_l2    : hidden i -> output j at [(j*N_HID+i)*W_W +: W_W], signed
//     bias_l2       : output j at [j*W_W +: W_W], signed
//     spk_out_l2    : output spikes of the latest timestep, held
//     step_done     : one-cycle strobe, N_IN+N_HID+3 cycles after acceptance
//     result_valid  : one-cycle strobe with step_done every T_STEPS timesteps
//     result_class  : argmax of output spike counts, held
//     busy          : high whenever the FSM is outside IDLE
//     overrun       : sticky, set by any pulse that arrives while busy
//
//   Handshake: there is no back-pressure. A pulse is taken only when busy is
//   low; a pulse while busy is dropped and recorded in overrun. Weight and bias
//   buses are read live and must stay stable while busy.
// ---------------------------------------------------------------------------
module snn_two_layer_seq import snn_pkg::*; #(
  parameter int N_IN       = DEF_N_IN,
  parameter int N_HID      = DEF_N_HID,
  parameter int N_OUT      = DEF_N_OUT,
  parameter int W_W        = DEF_W_W,
  parameter int MEM_W      = DEF_MEM_W,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int T_STEPS    = DEF_T_STEPS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pulse,
  input  logic [N_IN-1:0]             pixel_spk,
  input  logic [N_IN*N_HID*W_W-1:0]   weights_l1,
  input  logic [N_HID*W_W-1:0]        bias_l1,
  input  logic [N_HID*N_OUT*W_W-1:0]  weights_l2,
  input  logic [N_OUT*W_W-1:0]        bias_l2,
  output logic [N_OUT-1:0]            spk_out_l2,
  output logic                        step_done,
  output logic                        result_valid,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] result_class,
  output logic                        busy,
  output logic                        overrun
);

  localparam int IDX_MAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int CNT_W   = $clog2(T_STEPS + 1);
  localparam int CLS_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  snn_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_IN-1:0]    pix_q;
  logic [CNT_W-1:0]   step_q;
  logic [CNT_W-1:0]   cnt_q   [N_OUT];
  logic               step_done_q;
  logic               result_valid_q;
  logic [CLS_W-1:0]   class_q;
  logic               overrun_q;

  logic [N_HID-1:0]   hid_spk;
  logic [N_OUT-1:0]   out_spk;

  logic               acc1_en, acc2_en, fire1_en, fire2_en;
  logic [W_W-1:0]     w1_sel  [N_HID];
  logic [W_W-1:0]     w2_sel  [N_OUT];
  logic [CNT_W-1:0]   cnt_inc [N_OUT];
  logic [CNT_W-1:0]   best_cnt;
  logic [CLS_W-1:0]   best_idx;

  // Serial index decode: the current input (or hidden neuron) gates the
  // accumulate, and each neuron sees its own weight for that index.
  always_comb begin
    acc1_en  = 1'b0;
    acc2_en  = 1'b0;
    fire1_en = (state_q == S_FIRE1);
    fire2_en = (state_q == S_FIRE2);
    for (int j = 0; j < N_HID; j++) begin
      w1_sel[j] = '0;
    end
    for (int j = 0; j < N_OUT; j++) begin
      w2_sel[j] = '0;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (int'(idx_q) == i) begin
        acc1_en = (state_q == S_ACC1) && pix_q[i];
        for (int j = 0; j < N_HID; j++) begin
          w1_sel[j] = weights_l1[(j*N_IN + i)*W_W +: W_W];
        end
      end
    end
    for (int i = 0; i < N_HID; i++) begin
      if (int'(idx_q) == i) begin
        acc2_en = (state_q == S_ACC2) && hid_spk[i];
        for (int j = 0; j < N_OUT; j++) begin
          w2_sel[j] = weights_l2[(j*N_HID + i)*W_W +: W_W];
        end
      end
    end
  end

  // Counts are bumped in DONE from the held output spikes, so the argmax in
  // the final DONE cycle already includes the last timestep.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      cnt_inc[j] = cnt_q[j] + CNT_W'(out_spk[j]);
    end
    best_idx = '0;
    best_cnt = cnt_inc[0];
    for (int j = 1; j < N_OUT; j++) begin
      if (cnt_inc[j] > best_cnt) begin
        best_idx = CLS_W'(j);
        best_cnt = cnt_inc[j];
      end
    end
  end

  for (genvar j = 0; j < N_HID; j++) begin : g_hid
    snn_lif_neuron #(
      .W_W       (W_W),
      .MEM_W     (MEM_W),
      .THRESH    (THRESH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neuron (
      .clk      (clk),
      .reset    (reset),
      .acc_en_i (acc1_en),
      .weight_i (w1_sel[j]),
      .fire_en_i(fire1_en),
      .bias_i   (bias_l1[j*W_W +: W_W]),
      .spk_o    (hid_spk[j])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    snn_lif_neuron #(
      .W_W       (W_W),
      .MEM_W     (MEM_W),
      .THRESH    (THRESH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neuron (
      .clk      (clk),
      .reset    (reset),
      .acc_en_i (acc2_en),
      .weight_i (w2_sel[j]),
      .fire_en_i(fire2_en),
      .bias_i   (bias_l2[j*W_W +: W_W]),
      .spk_o    (out_spk[j])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      pix_q          <= '0;
      step_q         <= '0;
      step_done_q    <= 1'b0;
      result_valid_q <= 1'b0;
      class_q        <= '0;
      overrun_q      <= 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        cnt_q[j] <= '0;
      end
    end else begin
      step_done_q    <= 1'b0;
      result_valid_q <= 1'b0;
      if (pulse && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pulse) begin
            pix_q   <= pixel_spk;
            idx_q   <= '0;
            state_q <= S_ACC1;
          end
        end
        S_ACC1: begin
          if (idx_q == IDX_W'(N_IN - 1)) begin
            idx_q   <= '0;
            state_q <= S_FIRE1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_FIRE1: begin
          state_q <= S_ACC2;
        end
        S_ACC2: begin
          if (idx_q == IDX_W'(N_HID - 1)) begin
            idx_q   <= '0;
            state_q <= S_FIRE2;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_FIRE2: begin
          state_q <= S_DONE;
        end
        S_DONE: begin
          // The strobes are registered here, so they appear one cycle after
          // DONE, i.e. N_IN+N_HID+3 edges after the accepting edge.
          step_done_q <= 1'b1;
          state_q     <= S_IDLE;
          if (step_q == CNT_W'(T_STEPS - 1)) begin
            result_valid_q <= 1'b1;
            class_q        <= best_idx;
            step_q         <= '0;
            for (int j = 0; j < N_OUT; j++) begin
              cnt_q[j] <= '0;
            end
          end else begin
            step_q <= step_q + 1'b1;
            for (int j = 0; j < N_OUT; j++) begin
              cnt_q[j] <= cnt_inc[j];
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign spk_out_l2   = out_spk;
  assign step_done    = step_done_q;
  assign result_valid = result_valid_q;
  assign result_class = class_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_snn_two_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_snn_two_layer_seq
//   Directed bench for snn_two_layer_seq. A default-parameter instance runs a
//   table of single-path scenarios (8 timesteps each) plus hand-written
//   sequences for latency, overrun, mid-step reset and residual membrane; a
//   MEM_W=12 instance exercises membrane saturation.
// ---------------------------------------------------------------------------
module tb_snn_two_layer_seq;

  localparam int N_IN  = 25;
  localparam int N_HID = 5;
  localparam int N_OUT = 2;
  localparam int W_W   = 8;
  localparam int LAT   = N_IN + N_HID + 3;

`ifdef SNN_SOFT_RESET_EN
  localparam int EXP_RESIDUAL = 36;  // 100 - 64 kept after firing
`else
  localparam int EXP_RESIDUAL = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic                        pulse;
  logic [N_IN-1:0]             pixel_spk;
  logic [N_IN*N_HID*W_W-1:0]   weights_l1;
  logic [N_HID*W_W-1:0]        bias_l1;
  logic [N_HID*N_OUT*W_W-1:0]  weights_l2;
  logic [N_OUT*W_W-1:0]        bias_l2;
  logic [N_OUT-1:0]            spk_out_l2;
  logic                        step_done;
  logic                        result_valid;
  logic [0:0]                  result_class;
  logic                        busy;
  logic                        overrun;

  snn_two_layer_seq u_dut (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .pixel_spk   (pixel_spk),
    .weights_l1  (weights_l1),
    .bias_l1     (bias_l1),
    .weights_l2  (weights_l2),
    .bias_l2     (bias_l2),
    .spk_out_l2  (spk_out_l2),
    .step_done   (step_done),
    .result_valid(result_valid),
    .result_class(result_class),
    .busy        (busy),
    .overrun     (overrun)
  );

  // ---------------- saturation instance (MEM_W = 12) ----------------
  logic                        s_pulse;
  logic [N_IN-1:0]             s_pix;
  logic [N_IN*N_HID*W_W-1:0]   s_w1;
  logic [N_HID*W_W-1:0]        s_b1;
  logic [N_HID*N_OUT*W_W-1:0]  s_w2;
  logic [N_OUT*W_W-1:0]        s_b2;
  logic [N_OUT-1:0]            s_spk;
  logic                        s_done;
  logic                        s_rv;
  logic [0:0]                  s_rc;
  logic                        s_busy;
  logic                        s_ovr;

  snn_two_layer_seq #(.MEM_W(12)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .pulse       (s_pulse),
    .pixel_spk   (s_pix),
    .weights_l1  (s_w1),
    .bias_l1     (s_b1),
    .weights_l2  (s_w2),
    .bias_l2     (s_b2),
    .spk_out_l2  (s_spk),
    .step_done   (s_done),
    .result_valid(s_rv),
    .result_class(s_rc),
    .busy        (s_busy),
    .overrun     (s_ovr)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- vector table ----------------
  // One record = one 8-step scenario: a single nonzero layer-1 weight, bias of
  // hidden 0, up to two nonzero layer-2 weights, and the per-step spike
  // pattern / final class worked out by hand.
  typedef struct {
    logic [N_IN-1:0] pix;
    int w1_in, w1_hid, w1_val;
    int b1_0;
    int w2a_h, w2a_o, w2a_val;
    int w2b_h, w2b_o, w2b_val;
    logic [1:0] exp_spk;
    logic       exp_cls;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    pulse   = 1'b0;
    s_pulse = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_cfg(input vec_t v);
    pixel_spk  = v.pix;
    weights_l1 = '0;
    bias_l1    = '0;
    weights_l2 = '0;
    bias_l2    = '0;
    weights_l1[(v.w1_hid*N_IN + v.w1_in)*W_W +: W_W] = 8'(v.w1_val);
    bias_l1[0 +: W_W] = 8'(v.b1_0);
    weights_l2[(v.w2a_o*N_HID + v.w2a_h)*W_W +: W_W] = 8'(v.w2a_val);
    weights_l2[(v.w2b_o*N_HID + v.w2b_h)*W_W +: W_W] = 8'(v.w2b_val);
  endtask

  // Issue one pulse and wait (bounded) for step_done. extra_at > 0 raises
  // pulse again so it is sampled on that edge after acceptance.
  task automatic do_step(input int extra_at, output int lat, output logic rv,
                         output logic rc, output logic [1:0] spk);
    @(negedge clk);
    pulse = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    rv  = 1'b0;
    rc  = 1'b0;
    spk = 2'b00;
    for (int c = 1; c <= LAT + 8; c++) begin
      pulse = (c == extra_at);
      @(posedge clk);
      #1;
      if (step_done) begin
        lat = c;
        rv  = result_valid;
        rc  = result_class[0];
        spk = spk_out_l2;
        break;
      end
    end
    pulse = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int         lat;
  logic       rv;
  logic       rc;
  logic [1:0] spk;
  int         m;
  vec_t       zero_v;

  initial begin
    reset = 1'b0;  pulse = 1'b0;  pixel_spk = '0;
    weights_l1 = '0; bias_l1 = '0; weights_l2 = '0; bias_l2 = '0;
    s_pulse = 1'b0; s_pix = '1; s_w1 = {(N_IN*N_HID){8'h80}};
    s_b1 = '0; s_w2 = '0; s_b2 = '0;

    //            pix          w1 in/hid/val  b1_0  w2a h/o/val   w2b h/o/val  spk    cls
    vecs[0] = '{25'h0,         0, 0,   0,     70,   0, 1, 100,   0, 0,   0,   2'b10, 1'b1}; // single path
    vecs[1] = '{25'h0,         0, 0,   0,      0,   0, 0,   0,   0, 0,   0,   2'b00, 1'b0}; // all zero
    vecs[2] = '{25'h8,         3, 2,  80,      0,   2, 0,  90,   2, 1, -50,   2'b01, 1'b0}; // out0 only
    vecs[3] = '{25'h8,         3, 2,  80,      0,   2, 0,  90,   2, 1,  90,   2'b11, 1'b0}; // tie
    vecs[4] = '{25'h1000000,  24, 4, 100,      0,   4, 1, 127,   0, 0,   0,   2'b10, 1'b1}; // last indices
    vecs[5] = '{25'h1FFFFF7,   3, 2,  80,      0,   2, 0,  90,   0, 0,   0,   2'b00, 1'b0}; // gated input
    zero_v  = vecs[1];

    // Reset values
    do_reset();
    check("rst_spk",      32'(spk_out_l2),   0);
    check("rst_done",     32'(step_done),    0);
    check("rst_valid",    32'(result_valid), 0);
    check("rst_class",    32'(result_class), 0);
    check("rst_busy",     32'(busy),         0);
    check("rst_overrun",  32'(overrun),      0);

    // Exact latency and single-cycle strobe
    set_cfg(zero_v);
    do_step(0, lat, rv, rc, spk);
    check("lat_first", 32'(lat), 32'(LAT));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(step_done), 0);
    check("idle_after_step", 32'(busy), 0);

    // Table-driven scenarios
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_cfg(vecs[v]);
      for (int s = 1; s <= 8; s++) begin
        exp_q.push_back(vecs[v].exp_spk);
        do_step(0, lat, rv, rc, spk);
        check($sformatf("lat_v%0d_s%0d", v, s), 32'(lat), 32'(LAT));
        check($sformatf("spk_v%0d_s%0d", v, s), 32'(spk), 32'(exp_q.pop_front()));
        check($sformatf("valid_v%0d_s%0d", v, s), 32'(rv), 32'(s == 8));
        if (s == 8) begin
          check($sformatf("class_v%0d", v), 32'(rc), 32'(vecs[v].exp_cls));
        end
      end
    end

    // Membrane after a fire: hard clears, soft keeps 100 - 64
    do_reset();
    set_cfg(zero_v);
    bias_l1[0 +: W_W] = 8'd100;
    do_step(0, lat, rv, rc, spk);
    m = u_dut.g_hid[0].u_neuron.mem_q;
    check("residual_mem0", 32'(m), 32'(EXP_RESIDUAL));

    // Saturation at MEM_W = 12: 25 x -128 clamps at -2048, leak gives -1792
    do_reset();
    @(negedge clk);
    s_pulse = 1'b1;
    @(posedge clk);
    #1;
    s_pulse = 1'b0;
    repeat (N_IN) @(posedge clk);
    #1;
    m = u_sat.g_hid[0].u_neuron.mem_q;
    check("sat_acc_mem0", 32'(m), -32'sd2048);
    m = u_sat.g_hid[4].u_neuron.mem_q;
    check("sat_acc_mem4", 32'(m), -32'sd2048);
    @(posedge clk);
    #1;
    m = u_sat.g_hid[0].u_neuron.mem_q;
    check("sat_fire_mem0", 32'(m), -32'sd1792);
    lat = -1;
    for (int c = N_IN + 2; c <= LAT + 8; c++) begin
      @(posedge clk);
      #1;
      if (s_done) begin
        lat = c;
        break;
      end
    end
    check("sat_lat", 32'(lat), 32'(LAT));
    check("sat_spk", 32'(s_spk), 0);

    // Overrun: pulse during ACC1 is dropped, timing unchanged, flag sticky
    do_reset();
    set_cfg(vecs[0]);
    do_step(5, lat, rv, rc, spk);
    check("ovr_lat", 32'(lat), 32'(LAT));
    check("ovr_spk", 32'(spk), 32'(2'b10));
    check("ovr_flag", 32'(overrun), 1);
    do_step(0, lat, rv, rc, spk);
    check("ovr_lat2", 32'(lat), 32'(LAT));
    check("ovr_sticky", 32'(overrun), 1);

    // Pulse in the DONE cycle is dropped too
    do_reset();
    check("ovr_cleared", 32'(overrun), 0);
    set_cfg(zero_v);
    do_step(LAT, lat, rv, rc, spk);
    check("done_pulse_lat", 32'(lat), 32'(LAT));
    check("done_pulse_ovr", 32'(overrun), 1);
    @(posedge clk);
    #1;
    check("done_pulse_not_started", 32'(busy), 0);

    // Reset in the middle of ACC2, then a full fresh classification
    do_reset();
    set_cfg(vecs[0]);
    repeat (3) do_step(0, lat, rv, rc, spk);
    @(negedge clk);
    pulse = 1'b1;
    @(posedge clk);
    #1;
    pulse = 1'b0;
    repeat (N_IN + 3) @(posedge clk);
    #1;
    check("midacc2_busy", 32'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_spk", 32'(spk_out_l2), 0);
    m = u_dut.g_out[1].u_neuron.mem_q;
    check("midrst_mem_out1", 32'(m), 0);
    m = u_dut.g_hid[0].u_neuron.mem_q;
    check("midrst_mem_hid0", 32'(m), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      do_step(0, lat, rv, rc, spk);
      check($sformatf("post_lat_s%0d", s), 32'(lat), 32'(LAT));
      check($sformatf("post_spk_s%0d", s), 32'(spk), 32'(2'b10));
      check($sformatf("post_valid_s%0d", s), 32'(rv), 32'(s == 8));
      if (s == 8) begin
        check("post_class", 32'(rc), 1);
      end
    end
    check("post_overrun", 32'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
